// File: rtl/arm_run_pkg.sv
// arm_run_pkg: shared run-state encoding and breakpoint index width for arm_run_ctrl.
package arm_run_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } run_state_t;
    localparam int BP_IDX_W = 3;
endpackage

// File: rtl/arm_run_ctrl_bp_match.sv
// bp_match: NUM_BP parallel PC comparators with a lowest-index priority encoder.
//   pc      - current program counter
//   bp_addr - packed breakpoint addresses, slot i at [i*PC_W +: PC_W]
//   bp_en   - per-slot enable
//   match   - any enabled slot equals pc
//   idx     - lowest matching slot (0 when no match)
module bp_match
    import arm_run_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int NUM_BP = 2
) (
    input  logic [PC_W-1:0]        pc,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_en,
    output logic                   match,
    output logic [BP_IDX_W-1:0]    idx
);
    logic [NUM_BP-1:0] hit;
    for (genvar i = 0; i < NUM_BP; i++) begin : g_cmp
        assign hit[i] = bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pc);
    end
    assign match = |hit;
    // Scan from the top so the lowest matching slot is written last.
    always_comb begin
        idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) idx = hit[i] ? BP_IDX_W'(i) : idx;
    end
endmodule

// File: rtl/arm_run_ctrl.sv
// arm_run_ctrl: run control (clock enable, breakpoints, halt, watchdog, pixel enable) for the ARM core.
//   clk_50Mhz_in - free-running system clock (never gated)
//   reset        - asynchronous active-low reset
//   start        - pulse, leaves IDLE; mode_step selects PAUSE instead of RUN
//   resume/step  - pulses acting in PAUSE
//   pc           - registered PC from the core
//   bp_addr/bp_en- breakpoint slots and enables
//   cpu_en       - core / data-memory clock enable
//   pix_en       - one-cycle pulse every PIX_DIV clocks
//   state, done, timeout, bp_hit, bp_idx, cycle_count - status
module arm_run_ctrl
    import arm_run_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int HALT_PC = 408,
    parameter int NUM_BP  = 2,
    parameter int CYC_W   = 24,
    parameter int TIMEOUT = 0,
    parameter int PIX_DIV = 2
) (
    input  logic                   clk_50Mhz_in,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode_step,
    input  logic                   resume,
    input  logic                   step,
    input  logic [PC_W-1:0]        pc,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_en,
    output logic                   cpu_en,
    output logic                   pix_en,
    output logic [1:0]             state,
    output logic                   done,
    output logic                   timeout,
    output logic                   bp_hit,
    output logic [BP_IDX_W-1:0]    bp_idx,
    output logic [CYC_W-1:0]       cycle_count
);
    localparam int PIX_W = $clog2(PIX_DIV);
    localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT - 1);
    run_state_t st, st_nx;
    logic halt_now, bp_any, bp_now, skip, skip_nx, hit_nx, to_nx;
    logic [BP_IDX_W-1:0] idx_w, idx_nx;
    logic [PIX_W-1:0] pix_cnt;
    bp_match #(.PC_W(PC_W), .NUM_BP(NUM_BP)) u_bp (
        .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en), .match(bp_any), .idx(idx_w)
    );
    assign halt_now = pc > PC_W'(HALT_PC);
    assign bp_now   = bp_any && !skip;
    // Resume in the same cycle as step suppresses the step's enable.
    assign cpu_en = (st == RUN)   ? !halt_now && !bp_now :
                    (st == PAUSE) ? step && !resume && !halt_now : 1'b0;
    assign state  = st;
    assign done   = st == DONE;
    assign pix_en = pix_cnt == PIX_W'(PIX_DIV - 1);
    always_comb begin
        st_nx   = st;
        hit_nx  = bp_hit;
        idx_nx  = bp_idx;
        to_nx   = timeout;
        skip_nx = skip && !cpu_en;
        case (st)
            IDLE: st_nx = start ? (mode_step ? PAUSE : RUN) : IDLE;
            RUN: begin
                if (halt_now) begin
                    st_nx = DONE;
                end else if (bp_now) begin
                    st_nx  = PAUSE;
                    hit_nx = 1'b1;
                    idx_nx = idx_w;
                end else if (TIMEOUT != 0 && cycle_count == TO_LAST) begin
                    // cpu_en is high here, so the final instruction still runs.
                    st_nx = DONE;
                    to_nx = 1'b1;
                end
            end
            PAUSE: begin
                if (halt_now) begin
                    st_nx = DONE;
                end else if (resume) begin
                    st_nx   = RUN;
                    skip_nx = 1'b1;
                    hit_nx  = 1'b0;
                end else if (step) begin
                    hit_nx = 1'b0;
                end
            end
            default: st_nx = DONE;
        endcase
    end
    always_ff @(posedge clk_50Mhz_in or negedge reset) begin
        if (!reset) begin
            st          <= IDLE;
            skip        <= 1'b0;
            bp_hit      <= 1'b0;
            bp_idx      <= '0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            pix_cnt     <= '0;
        end else begin
            st          <= st_nx;
            skip        <= skip_nx;
            bp_hit      <= hit_nx;
            bp_idx      <= idx_nx;
            timeout     <= to_nx;
            cycle_count <= (cpu_en && !(&cycle_count)) ? cycle_count + CYC_W'(1) : cycle_count;
            pix_cnt     <= pix_en ? '0 : pix_cnt + PIX_W'(1);
        end
    end
endmodule

// File: tb/tb_arm_run_ctrl.sv
// tb_arm_run_ctrl: directed bench for arm_run_ctrl with a behavioural model checked every cycle.
module tb_arm_run_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, mode_step = 1'b0, resume = 1'b0, step = 1'b0;
    logic [63:0] bp_addr = {32'd40, 32'd0};
    logic [1:0]  bp_en = 2'b00;
    logic [31:0] pc0, pc1;
    logic ce0, pe0, dn0, to0, hit0, ce1, pe1, dn1, to1, hit1;
    logic [1:0] st0, st1;
    logic [2:0] idx0, idx1;
    logic [23:0] cc0, cc1;
    int n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    arm_run_ctrl u0 (
        .clk_50Mhz_in(clk), .reset(reset), .start(start), .mode_step(mode_step),
        .resume(resume), .step(step), .pc(pc0), .bp_addr(bp_addr), .bp_en(bp_en),
        .cpu_en(ce0), .pix_en(pe0), .state(st0), .done(dn0), .timeout(to0),
        .bp_hit(hit0), .bp_idx(idx0), .cycle_count(cc0)
    );
    arm_run_ctrl #(.TIMEOUT(10), .PIX_DIV(4)) u1 (
        .clk_50Mhz_in(clk), .reset(reset), .start(start), .mode_step(mode_step),
        .resume(resume), .step(step), .pc(pc1), .bp_addr(bp_addr), .bp_en(2'b00),
        .cpu_en(ce1), .pix_en(pe1), .state(st1), .done(dn1), .timeout(to1),
        .bp_hit(hit1), .bp_idx(idx1), .cycle_count(cc1)
    );

    // Core stand-in: PC advances by 4 on every enabled cycle; the second DUT's PC is held at 0.
    always @(posedge clk or negedge reset)
        if (!reset) pc0 <= 0;
        else if (ce0) pc0 <= pc0 + 4;
    assign pc1 = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int st; bit skip; bit tmo; bit hit; int idx; longint cyc; int pix;
    } m_t;
    m_t m0 = '{default: 0};
    m_t m1 = '{default: 0};
    localparam longint CMAX = (64'd1 << 24) - 1;

    function automatic int bp_low(logic [31:0] p, logic [1:0] en, bit skip);
        if (skip) return -1;
        for (int i = 0; i < 2; i++) if (en[i] && bp_addr[i*32 +: 32] == p) return i;
        return -1;
    endfunction

    function automatic bit m_en(m_t m, logic [31:0] p, logic [1:0] en);
        bit halt = p > 408;
        int b = bp_low(p, en, m.skip);
        return (m.st == 1 && !halt && b < 0) || (m.st == 2 && step && !resume && !halt);
    endfunction

    function automatic m_t m_next(m_t m, logic [31:0] p, logic [1:0] en, int to, int div);
        m_t n = m;
        bit halt = p > 408;
        int b = bp_low(p, en, m.skip);
        if (m_en(m, p, en)) begin
            n.skip = 0;
            if (n.cyc < CMAX) n.cyc++;
        end
        n.pix = (m.pix + 1) % div;
        case (m.st)
            0: if (start) n.st = mode_step ? 2 : 1;
            1: if (halt) n.st = 3;
               else if (b >= 0) begin n.st = 2; n.hit = 1; n.idx = b; end
               else if (to != 0 && m.cyc == to - 1) begin n.st = 3; n.tmo = 1; end
            2: if (halt) n.st = 3;
               else if (resume) begin n.st = 1; n.skip = 1; n.hit = 0; end
               else if (step) n.hit = 0;
            default: ;
        endcase
        return n;
    endfunction

    task automatic cmp(input string d, input m_t m, input logic [31:0] p, input logic [1:0] en,
                       input int div, input logic ce, input logic pe, input logic [1:0] st,
                       input logic dn, input logic to, input logic hit, input logic [2:0] idx,
                       input logic [23:0] cc);
        chk({d, ".cpu_en"}, 64'(ce), 64'(m_en(m, p, en)));
        chk({d, ".pix_en"}, 64'(pe), 64'(m.pix == div - 1));
        chk({d, ".state"}, 64'(st), 64'(m.st));
        chk({d, ".done"}, 64'(dn), 64'(m.st == 3));
        chk({d, ".timeout"}, 64'(to), 64'(m.tmo));
        chk({d, ".bp_hit"}, 64'(hit), 64'(m.hit));
        chk({d, ".bp_idx"}, 64'(idx), 64'(m.idx));
        chk({d, ".cycle_count"}, 64'(cc), 64'(m.cyc));
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            m0 = '{default: 0};
            m1 = '{default: 0};
        end else begin
            m0 = m_next(m0, pc0, bp_en, 0, 2);
            m1 = m_next(m1, pc1, 2'b00, 10, 4);
        end
    end

    always @(negedge clk) begin
        m_t r0, r1;
        r0 = reset ? m0 : '{default: 0};
        r1 = reset ? m1 : '{default: 0};
        cmp("d0", r0, pc0, bp_en, 2, ce0, pe0, st0, dn0, to0, hit0, idx0, cc0);
        cmp("d1", r1, pc1, 2'b00, 4, ce1, pe1, st1, dn1, to1, hit1, idx1, cc1);
    end

    task automatic do_reset(input bit pix_chk);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        if (pix_chk) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("pix0_seq", 64'(pe0), 64'(i % 2));
                chk("pix1_seq", 64'(pe1), 64'(i == 3));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_st(input logic [1:0] s, input int lim, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (st0 !== s && n < lim);
        chk(nm, 64'(st0), 64'(s));
    endtask

    initial begin
        do_reset(1'b1);
        // Free run to the halt address
        pulse_start();
        @(negedge clk);
        chk("t1_state_run", 64'(st0), 64'd1);
        chk("t1_cpu_en", 64'(ce0), 64'd1);
        wait_st(2'd3, 300, "t1_reach_done");
        chk("t1_pc", 64'(pc0), 64'd412);
        chk("t1_cycles", 64'(cc0), 64'd103);
        chk("t1_done", 64'(dn0), 64'd1);
        chk("t1_cpu_en_off", 64'(ce0), 64'd0);
        chk("wd_state", 64'(st1), 64'd3);
        chk("wd_timeout", 64'(to1), 64'd1);
        chk("wd_cycles", 64'(cc1), 64'd10);
        // Breakpoint on slot 1 at pc 40
        do_reset(1'b0);
        bp_en = 2'b10;
        pulse_start();
        wait_st(2'd2, 100, "t2_reach_pause");
        chk("t2_pc", 64'(pc0), 64'd40);
        chk("t2_cpu_en", 64'(ce0), 64'd0);
        chk("t2_bp_hit", 64'(hit0), 64'd1);
        chk("t2_bp_idx", 64'(idx0), 64'd1);
        chk("t2_cycles", 64'(cc0), 64'd10);
        @(posedge clk); #1 resume = 1'b1;
        @(posedge clk); #1 resume = 1'b0;
        @(negedge clk);
        chk("t2_resume_run", 64'(st0), 64'd1);
        chk("t2_skip_exec", 64'(ce0), 64'd1);
        chk("t2_hit_clear", 64'(hit0), 64'd0);
        @(negedge clk);
        chk("t2_pc_past", 64'(pc0), 64'd44);
        wait_st(2'd3, 300, "t2_reach_done");
        chk("t2_cycles_end", 64'(cc0), 64'd103);
        // Single-step mode
        do_reset(1'b0);
        bp_en = 2'b00;
        mode_step = 1'b1;
        pulse_start();
        mode_step = 1'b0;
        repeat (3) begin
            @(posedge clk); #1 step = 1'b1;
            @(posedge clk); #1 step = 1'b0;
        end
        @(negedge clk);
        chk("t3_cycles", 64'(cc0), 64'd3);
        chk("t3_state", 64'(st0), 64'd2);
        chk("t3_pc", 64'(pc0), 64'd12);
        @(posedge clk); #1 step = 1'b1; resume = 1'b1;
        @(negedge clk);
        chk("t3_both_cpu_en", 64'(ce0), 64'd0);
        @(posedge clk); #1 step = 1'b0; resume = 1'b0;
        @(negedge clk);
        chk("t3_both_run", 64'(st0), 64'd1);
        chk("t3_both_cycles", 64'(cc0), 64'd3);
        wait_st(2'd3, 300, "t3_reach_done");
        chk("t3_cycles_end", 64'(cc0), 64'd103);
        chk("t3_wd_cycles", 64'(cc1), 64'd10);
        // Asynchronous reset mid-run
        do_reset(1'b0);
        pulse_start();
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t4_async_cpu_en", 64'(ce0), 64'd0);
        chk("t4_async_state", 64'(st0), 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("t4_cycles", 64'(cc0), 64'd0);
        chk("t4_state", 64'(st0), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
